fir_coeff_ctrl: RTL
===================

Name: fir_coeff_ctrl

Overview:
Run-time coefficient controller for the MSO fir datapath. It accepts coefficient writes into a shadow bank through a valid/ready port. On a commit request it swaps the shadow bank into the active bank on a sample boundary. It then clears the FIR delay line and holds a "settled" flag low until NUM_TAPS fresh samples have filled the pipeline. It sits between the capture-control register interface and the fir instance, driving its flat coeff bus.

Parameters:
NUM_TAPS, 4, number of FIR taps (>= 2)
COEFF_WIDTH, 8, signed coefficient width in bits
ADDR_WIDTH, $clog2(NUM_TAPS), width of tap address (derived, not overridden)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_valid  input  1  coefficient write request
wr_ready  output  1  controller can accept a write
wr_addr  input  ADDR_WIDTH  tap index to write
wr_data  input  COEFF_WIDTH  signed coefficient value
wr_err  output  1  one-cycle pulse: accepted write had wr_addr >= NUM_TAPS
commit  input  1  request shadow-to-active swap (single-cycle pulse)
sample_en  input  1  FIR accepts a new sample this cycle
coeff  output  NUM_TAPS*COEFF_WIDTH  active bank; tap i at bits [i*COEFF_WIDTH +: COEFF_WIDTH]
fir_clr  output  1  one-cycle clear of FIR delay line, coincident with coeff update
busy  output  1  commit in progress (state != IDLE)
settled  output  1  FIR output valid for current coefficients

Behaviour:
- Reset (rst=1 at an edge): shadow bank and active bank = 0, coeff = 0, state IDLE, wr_ready = 1, wr_err = 0, fir_clr = 0, busy = 0, settled = 0. Reset mid-commit aborts it and discards all bank contents.
- States: IDLE, PENDING, FLUSH. busy = (state != IDLE). wr_ready = (state == IDLE), driven combinationally from state.
- Write: accepted when wr_valid && wr_ready.
  - shadow[wr_addr] <= wr_data at that edge.
  - If wr_addr >= NUM_TAPS: write discarded, wr_err = 1 for the next cycle only.
  - Writes while busy are not accepted; the writer must hold wr_valid.
- Shadow persists across commits, so partial updates are legal.
- IDLE -> PENDING on commit = 1. Same-cycle write plus commit: the write lands in shadow and is included in the swap. settled drops to 0 the cycle after commit is accepted. commit while busy is ignored (no queuing).
- PENDING:
  - Wait for sample_en.
  - On the edge where sample_en = 1: active <= shadow, fir_clr = 1 for exactly the following cycle, flush counter <= NUM_TAPS-1, state -> FLUSH.
- FLUSH:
  - Each cycle with sample_en = 1: if counter == 0, go to IDLE and set settled = 1; else decrement the counter.
  - Cycles without sample_en hold state.
- Latency, with sample_en held high and commit at cycle 0: coeff/fir_clr change at cycle 2; FLUSH spans cycles 2..NUM_TAPS+1; settled = 1 and wr_ready = 1 at cycle NUM_TAPS+2. For NUM_TAPS = 4, settled rises at cycle 6.
- settled stays 1 until the next accepted commit. It is 0 from reset until the first commit completes.
- coeff changes only on the PENDING->FLUSH edge, never partially.

Decomposition:
- Shared package/header fir_pkg: state encodings (ST_IDLE, ST_PENDING, ST_FLUSH); coeff bus packing macro/function (tap index to bit slice), also used by fir.
- One sub-module, fir_coeff_bank: dual register bank (shadow and active) with write port, swap strobe and flat coeff output.
- FSM and flush counter stay in the top.

Test Plan:
1. Reset then idle 10 cycles -> coeff = 32'h0, busy = 0, settled = 0, wr_ready = 1, fir_clr never asserted.
2. Write taps 3..0 = 4, 3, -1, -2, then commit with sample_en = 1 -> two cycles after commit coeff = 32'h0403FFFE and fir_clr pulses 1 cycle; settled rises 4 cycles after that.
3. Commit with sample_en low for 7 cycles, then sample_en every other cycle -> coeff unchanged while PENDING; the swap occurs on the first sample_en; settled after 4 further sample_en pulses; commit pulses during busy ignored.
4. Write wr_addr = 3 (NUM_TAPS = 3 build) or out-of-range address -> wr_err 1-cycle pulse, shadow unchanged, later commit shows old value.
5. Write tap 1 = 8'h7F in the same cycle as commit -> committed coeff tap 1 = 8'h7F; with wr_valid held during busy, wr_ready = 0 until IDLE, then the write is accepted exactly once.
6. Assert rst during FLUSH -> next cycle coeff = 0, state IDLE, settled = 0, busy = 0; a subsequent commit of an unwritten shadow yields coeff = 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath and its coefficient controller:
// controller state encodings and the flat coeff bus packing helper.
package fir_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    // Tap i of a flat coefficient bus occupies [coeff_lsb(i, W) +: W].
    function automatic int coeff_lsb(input int tap, input int width);
        return tap * width;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Dual coefficient register bank: writable shadow copy plus an active copy
// that is loaded from the shadow, all taps at once, on a swap strobe.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int NUM_TAPS    = 4,
    parameter int COEFF_WIDTH = 8,
    parameter int ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [COEFF_WIDTH-1:0]          wr_data,
    input  logic                            swap,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff
);

    // Addresses beyond the last tap match no tap, so such writes vanish here.
    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            logic [COEFF_WIDTH-1:0] shadow_reg;
            logic [COEFF_WIDTH-1:0] active_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
                        shadow_reg <= wr_data;
                    end
                    if (swap) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            assign coeff[coeff_lsb(gi, COEFF_WIDTH) +: COEFF_WIDTH] = active_reg;
        end
    endgenerate

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Run-time FIR coefficient controller: shadow writes, sample-aligned commit
// into the active bank, delay-line clear and a settle countdown.
module fir_coeff_ctrl
    import fir_pkg::*;
#(
    parameter int NUM_TAPS    = 4,
    parameter int COEFF_WIDTH = 8,
    localparam int ADDR_WIDTH = $clog2(NUM_TAPS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [COEFF_WIDTH-1:0]          wr_data,
    output logic                            wr_err,
    input  logic                            commit,
    input  logic                            sample_en,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
    output logic                            fir_clr,
    output logic                            busy,
    output logic                            settled
);

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] flush_cnt_reg;
    logic                  fir_clr_reg;
    logic                  wr_err_reg;
    logic                  settled_reg;

    logic wr_accept;
    logic wr_out_of_range;
    logic commit_accept;
    logic swap;
    logic flush_step;
    logic flush_done;

    assign wr_ready        = (state_reg == ST_IDLE);
    assign busy            = (state_reg != ST_IDLE);
    assign wr_accept       = wr_valid && wr_ready;
    assign wr_out_of_range = ({1'b0, wr_addr} >= (ADDR_WIDTH + 1)'(NUM_TAPS));
    assign commit_accept   = commit && (state_reg == ST_IDLE);
    assign swap            = (state_reg == ST_PENDING) && sample_en;
    assign flush_step      = (state_reg == ST_FLUSH) && sample_en;
    assign flush_done      = flush_step && (flush_cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (commit_accept) state_next = ST_PENDING;
            ST_PENDING: if (swap)          state_next = ST_FLUSH;
            ST_FLUSH:   if (flush_done)    state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            flush_cnt_reg <= '0;
            fir_clr_reg   <= 1'b0;
            wr_err_reg    <= 1'b0;
            settled_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fir_clr_reg <= swap;
            wr_err_reg  <= wr_accept && wr_out_of_range;

            // NUM_TAPS sample_en pulses in FLUSH refill the delay line.
            if (swap) begin
                flush_cnt_reg <= ADDR_WIDTH'(NUM_TAPS - 1);
            end else if (flush_step && !flush_done) begin
                flush_cnt_reg <= flush_cnt_reg - ADDR_WIDTH'(1);
            end

            if (commit_accept) begin
                settled_reg <= 1'b0;
            end else if (flush_done) begin
                settled_reg <= 1'b1;
            end
        end
    end

    assign fir_clr = fir_clr_reg;
    assign wr_err  = wr_err_reg;
    assign settled = settled_reg;

    fir_coeff_bank #(
        .NUM_TAPS   (NUM_TAPS),
        .COEFF_WIDTH(COEFF_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_accept),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .swap   (swap),
        .coeff  (coeff)
    );

endmodule
